// File: rtl/frame_normalizer_auto.sv
// Frame normalizer: maps a DEPTH-word signed frame onto 0..2^OUTW-1 using either
// a manual min/range or a measured min/max (auto scan pass), writing the result
// into a display buffer. Optional macro FRAME_NORM_ROUND_EN selects round-half-up
// on the final shift; truncation otherwise. Latency is the same in both builds.

// Restoring unsigned divider: quotient ready WIDTH cycles after i_start.
module divu_int #(
    parameter int unsigned WIDTH = 20
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_q
);
    localparam int unsigned CNTW = $clog2(WIDTH + 1);

    logic             busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, b_q, b_d;
    logic [WIDTH:0]   trial;

    // One quotient bit per cycle; valid is low for a zero divisor.
    always_comb begin
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        b_d     = b_q;
        trial   = {rem_q, quo_q[WIDTH-1]};
        if (i_start) begin
            busy_d  = 1'b1;
            valid_d = 1'b0;
            cnt_d   = CNTW'(WIDTH);
            rem_d   = '0;
            quo_d   = i_a;
            b_d     = i_b;
        end else if (busy_q) begin
            if (trial >= {1'b0, b_q}) begin
                rem_d = WIDTH'(trial - {1'b0, b_q});
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNTW'(1);
            if (cnt_q == CNTW'(1)) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                valid_d = (b_q != '0);
            end
        end
    end

    // Divider state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            b_q     <= '0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            b_q     <= b_d;
        end
    end

    assign o_done  = done_q;
    assign o_valid = valid_q;
    assign o_q     = quo_q;
endmodule

module frame_normalizer_auto #(
    parameter int unsigned DATAW     = 16,
    parameter int unsigned OUTW      = 8,
    parameter int unsigned DEPTH     = 768,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned FRACW     = 12,
    parameter int unsigned MIN_RANGE = 100,
    localparam int unsigned ADDRW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_auto,
    input  logic [DATAW-1:0] i_min,
    input  logic [DATAW-1:0] i_range,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_rd_valid,
    output logic [ADDRW-1:0] o_rd_addr,
    input  logic [DATAW-1:0] i_rd_data,
    output logic             o_wr_valid,
    output logic [ADDRW-1:0] o_wr_addr,
    output logic [OUTW-1:0]  o_wr_data,
    output logic [DATAW-1:0] o_min,
    output logic [DATAW-1:0] o_range,
    output logic             o_clip,
    output logic             o_start_ignored
);
    localparam int unsigned SCW  = OUTW + FRACW;
    localparam int unsigned PW   = DATAW + SCW;
    localparam logic [ADDRW-1:0] LAST        = ADDRW'(DEPTH - 1);
    localparam logic [DATAW-1:0] RANGE_FLOOR = DATAW'(MIN_RANGE);
    localparam logic [OUTW-1:0]  OMAX        = {OUTW{1'b1}};
    localparam logic [SCW-1:0]   DIV_A       = {OMAX, {FRACW{1'b0}}};
    localparam logic [PW-1:0]    HALF        = PW'(1) << (FRACW - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_SCALE = 2'd2;
    localparam logic [1:0] S_NORM  = 2'd3;

    logic [1:0]                   state_q, state_d;
    logic                         busy_q, busy_d, done_q, done_d;
    logic                         rd_valid_q, rd_valid_d;
    logic [ADDRW-1:0]             rd_addr_q, rd_addr_d;
    logic [RD_LAT-1:0]            rv_q, rv_d;
    logic [RD_LAT-1:0][ADDRW-1:0] ra_q, ra_d;
    logic [DATAW-1:0]             min_q, min_d, max_q, max_d;
    logic [DATAW-1:0]             smin_q, smin_d, range_q, range_d;
    logic [SCW-1:0]               scale_q, scale_d;
    logic                         div_start_q, div_start_d;
    logic                         s1_valid_q, s1_valid_d;
    logic [ADDRW-1:0]             s1_addr_q, s1_addr_d;
    logic [DATAW-1:0]             delta_q, delta_d;
    logic                         wr_valid_q, wr_valid_d;
    logic [ADDRW-1:0]             wr_addr_q, wr_addr_d;
    logic [OUTW-1:0]              wr_data_q, wr_data_d;
    logic                         clip_q, clip_d, ign_q, ign_d;

    logic             dv;
    logic [ADDRW-1:0] da;
    logic [DATAW-1:0] cur_min, cur_max;
    logic [DATAW:0]   delta_s;
    logic [PW-1:0]    prod, shf;
    logic             div_done, div_valid;
    logic [SCW-1:0]   div_q;

    function automatic logic [DATAW-1:0] floor_rng(input logic [DATAW-1:0] r);
        return (r < RANGE_FLOOR) ? RANGE_FLOOR : r;
    endfunction

    divu_int #(.WIDTH(SCW)) u_div (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (div_start_q),
        .i_a     (DIV_A),
        .i_b     (SCW'(range_q)),
        .o_done  (div_done),
        .o_valid (div_valid),
        .o_q     (div_q)
    );

    // Next-state, read sequencing and the two-stage normalize pipeline.
    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        rd_valid_d  = rd_valid_q;
        rd_addr_d   = rd_addr_q;
        min_d       = min_q;
        max_d       = max_q;
        smin_d      = smin_q;
        range_d     = range_q;
        scale_d     = scale_q;
        div_start_d = 1'b0;
        clip_d      = clip_q;
        ign_d       = ign_q;

        rv_d[0] = rd_valid_q;
        ra_d[0] = rd_addr_q;
        for (int k = 1; k < int'(RD_LAT); k++) begin
            rv_d[k] = rv_q[k-1];
            ra_d[k] = ra_q[k-1];
        end
        dv = rv_q[RD_LAT-1];
        da = ra_q[RD_LAT-1];

        cur_min = (da == '0 || $signed(i_rd_data) < $signed(min_q)) ? i_rd_data : min_q;
        cur_max = (da == '0 || $signed(i_rd_data) > $signed(max_q)) ? i_rd_data : max_q;
        delta_s = {i_rd_data[DATAW-1], i_rd_data} - {smin_q[DATAW-1], smin_q};

        s1_valid_d = 1'b0;
        s1_addr_d  = da;
        delta_d    = delta_q;

        prod = PW'(delta_q) * PW'(scale_q);
`ifdef FRAME_NORM_ROUND_EN
        shf  = (prod + HALF) >> FRACW;
`else
        shf  = prod >> FRACW;
`endif
        wr_valid_d = s1_valid_q;
        wr_addr_d  = s1_addr_q;
        wr_data_d  = (shf > PW'(OMAX)) ? OMAX : shf[OUTW-1:0];

        // Read counter stops at the last address; no wrap.
        if (rd_valid_q) begin
            if (rd_addr_q == LAST) rd_valid_d = 1'b0;
            else                   rd_addr_d  = rd_addr_q + ADDRW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    clip_d = 1'b0;
                    ign_d  = 1'b0;
                    if (i_auto) begin
                        state_d    = S_SCAN;
                        rd_valid_d = 1'b1;
                        rd_addr_d  = '0;
                    end else begin
                        state_d     = S_SCALE;
                        smin_d      = i_min;
                        range_d     = floor_rng(i_range);
                        div_start_d = 1'b1;
                    end
                end
            end
            S_SCAN: begin
                if (dv) begin
                    min_d = cur_min;
                    max_d = cur_max;
                    if (da == LAST) begin
                        state_d     = S_SCALE;
                        smin_d      = cur_min;
                        range_d     = floor_rng(cur_max - cur_min);
                        div_start_d = 1'b1;
                    end
                end
            end
            S_SCALE: begin
                if (div_done && div_valid) begin
                    scale_d    = div_q;
                    state_d    = S_NORM;
                    rd_valid_d = 1'b1;
                    rd_addr_d  = '0;
                end
            end
            S_NORM: begin
                if (dv) begin
                    s1_valid_d = 1'b1;
                    if (delta_s[DATAW]) begin
                        delta_d = '0;
                        clip_d  = 1'b1;
                    end else if (delta_s[DATAW-1:0] > range_q) begin
                        delta_d = range_q;
                        clip_d  = 1'b1;
                    end else begin
                        delta_d = delta_s[DATAW-1:0];
                    end
                end
                if (wr_valid_q && wr_addr_q == LAST) done_d  = 1'b1;
                if (done_q)                          state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (i_start && state_q != S_IDLE) ign_d = 1'b1;
        busy_d = (state_d != S_IDLE);
    end

    // State and pipeline registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_addr_q   <= '0;
            rv_q        <= '0;
            ra_q        <= '0;
            min_q       <= '0;
            max_q       <= '0;
            smin_q      <= '0;
            range_q     <= '0;
            scale_q     <= '0;
            div_start_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            delta_q     <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            clip_q      <= 1'b0;
            ign_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_valid_q  <= rd_valid_d;
            rd_addr_q   <= rd_addr_d;
            rv_q        <= rv_d;
            ra_q        <= ra_d;
            min_q       <= min_d;
            max_q       <= max_d;
            smin_q      <= smin_d;
            range_q     <= range_d;
            scale_q     <= scale_d;
            div_start_q <= div_start_d;
            s1_valid_q  <= s1_valid_d;
            s1_addr_q   <= s1_addr_d;
            delta_q     <= delta_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            clip_q      <= clip_d;
            ign_q       <= ign_d;
        end
    end

    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_rd_valid      = rd_valid_q;
    assign o_rd_addr       = rd_addr_q;
    assign o_wr_valid      = wr_valid_q;
    assign o_wr_addr       = wr_addr_q;
    assign o_wr_data       = wr_data_q;
    assign o_min           = smin_q;
    assign o_range         = range_q;
    assign o_clip          = clip_q;
    assign o_start_ignored = ign_q;
endmodule
